// File: rtl/seq_div_7by3.sv
// seq_div_7by3
// ------------
// Sequential 7-bit by 3-bit unsigned divider using restoring division, one
// quotient bit per clock, most significant bit first.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst_n        asynchronous, active-low reset
//   start        division request, sampled on the rising edge
//   dividend     7-bit unsigned dividend, captured with an accepted start
//   divisor      3-bit unsigned divisor, captured with an accepted start
//   busy         high while a division is in progress
//   done         one-cycle pulse when the result registers have been written
//   quotient     7-bit result, held until the next accepted start
//   remainder    3-bit result, held until the next accepted start
//   div_by_zero  set with done when the captured divisor was zero
//   state_dbg    current FSM state (IDLE=0, CALC=1, FINISH=2) for checkers
//
// Handshake: start is a request, not a valid/ready pair. It is accepted only
// on an edge where the FSM is in IDLE (busy=0); on any other edge it is
// ignored and the operands in flight are untouched. The cycle in which done
// is high is already IDLE, so a start held there is accepted on the next
// edge, giving back-to-back operations with no gap cycle.
//
// Timing for an accepted start at edge k:
//   divisor != 0 : CALC on edges k+1..k+7, results and done at edge k+8
//   divisor == 0 : results (quotient=7'h7F, remainder=0, div_by_zero=1)
//                  and done at edge k+1

module seq_div_7by3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] dividend,
  input  logic [2:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [6:0] quotient,
  output logic [2:0] remainder,
  output logic       div_by_zero,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0] state;
  logic [6:0] dvd_r;    // captured dividend
  logic [2:0] dvs_r;    // captured divisor
  logic [3:0] part;     // partial remainder
  logic [6:0] q_work;   // quotient bits built up during CALC
  logic [2:0] cnt;      // index of the dividend/quotient bit handled this step

  // One restoring step. The partial remainder is always below the divisor
  // (at most 6), so after the shift it still fits in four bits and only its
  // low three bits need to be carried forward.
  logic [3:0] shifted;
  logic [3:0] diff;
  logic       ge;

  always_comb begin
    shifted = {part[2:0], dvd_r[cnt]};
    ge      = (shifted >= {1'b0, dvs_r});
    diff    = shifted - {1'b0, dvs_r};
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_r       <= 7'd0;
      dvs_r       <= 3'd0;
      part        <= 4'd0;
      q_work      <= 7'd0;
      cnt         <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 7'd0;
      remainder   <= 3'd0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_r       <= dividend;
            dvs_r       <= divisor;
            part        <= 4'd0;
            q_work      <= 7'd0;
            cnt         <= 3'd6;
            quotient    <= 7'd0;
            remainder   <= 3'd0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            // A zero divisor skips the iteration entirely.
            state       <= (divisor == 3'd0) ? FINISH : CALC;
          end
        end

        CALC: begin
          part        <= ge ? diff : shifted;
          q_work[cnt] <= ge;
          if (cnt == 3'd0) begin
            state <= FINISH;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        FINISH: begin
          if (dvs_r == 3'd0) begin
            quotient    <= 7'h7F;
            remainder   <= 3'd0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_work;
            remainder   <= part[2:0];
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          // Unreachable encoding: recover to IDLE without producing a result.
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
